lvs_out_arbiter: RTL and testbench

LVS_OUT_ARBITER -- requirements
Module: lvs_out_arbiter

---
 rtl/lvs_out_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_lvs_out_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lvs_out_arbiter.sv
// lvs_out_arbiter: round-robin arbiter that funnels LVS words from NUM_REQ
// requesters into one registered output stage, counting output handshakes.
//
// Optional feature macro: LVS_ARB_LIMIT_EN
//   defined   -> run stops in DONE after MAX_ENTRIES handshakes until clear/rst
//   undefined -> no DONE state, done tied low, entry_cnt free-runs and wraps
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous run restart (IDLE, entry_cnt=0, last grant kept)
//   req_valid/data  per-requester word offer; requester i at [i*DATA_W +: DATA_W]
//   req_ready       combinational one-hot grant
//   out_valid/data  registered output word, out_src = granting requester index
//   out_ready       downstream accept
//   entry_cnt       output handshakes completed this run
//   done            run-complete flag (LVS_ARB_LIMIT_EN only)
module lvs_out_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 256,
    parameter int unsigned MAX_ENTRIES = 47,
    localparam int unsigned SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic [7:0]                entry_cnt,
    output logic                      done
);

    localparam int unsigned CNT_W = 8;

    // entry_cnt is 8 bits wide, so the run limit must fit in it
    if (MAX_ENTRIES == 0 || MAX_ENTRIES > 255) begin : g_bad_max_entries
        $error("lvs_out_arbiter: MAX_ENTRIES must be in 1..255");
    end

`ifdef LVS_ARB_LIMIT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;
`endif

    state_e               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [SRC_W-1:0]     out_src_q, out_src_d;
    logic [SRC_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     entry_cnt_q, entry_cnt_d;
`ifdef LVS_ARB_LIMIT_EN
    logic                 done_q, done_d;
`endif

    logic                 hs_c;
    logic                 limit_hit_c;
    logic                 load_en_c;
    logic                 grant_found_c;
    logic [SRC_W-1:0]     grant_idx_c;
    logic [NUM_REQ-1:0]   grant_c;
    int unsigned          rr_idx;

    assign hs_c = out_valid_q && out_ready;

    // Handshake that completes the run: no new word may be taken alongside it
`ifdef LVS_ARB_LIMIT_EN
    assign limit_hit_c = hs_c && (entry_cnt_q == CNT_W'(MAX_ENTRIES - 1));
`else
    assign limit_hit_c = 1'b0;
`endif

    // Output register can take a word when empty, or when it is being drained
    assign load_en_c = !rst && !clear && !limit_hit_c &&
                       ((state_q == IDLE) || ((state_q == BUSY) && out_ready));

    // Round-robin search starting one past the last accepted requester
    always_comb begin
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        rr_idx        = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (32'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found_c && req_valid[SRC_W'(rr_idx)]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = SRC_W'(rr_idx);
            end
        end
    end

    always_comb begin
        grant_c = '0;
        if (load_en_c && grant_found_c) begin
            grant_c[grant_idx_c] = 1'b1;
        end
    end

    assign req_ready = grant_c;

    // Next-state and output-register update
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        entry_cnt_d  = entry_cnt_q;
`ifdef LVS_ARB_LIMIT_EN
        done_d       = done_q;
`endif
        if (clear) begin
            // Restart drops the held word; a same-cycle handshake is not counted
            state_d     = IDLE;
            out_valid_d = 1'b0;
            entry_cnt_d = '0;
`ifdef LVS_ARB_LIMIT_EN
            done_d      = 1'b0;
`endif
        end else begin
            if (hs_c) begin
                entry_cnt_d = entry_cnt_q + CNT_W'(1);
            end
`ifdef LVS_ARB_LIMIT_EN
            if (limit_hit_c) begin
                state_d     = DONE;
                out_valid_d = 1'b0;
                done_d      = 1'b1;
            end else
`endif
            if (|grant_c) begin
                state_d      = BUSY;
                out_valid_d  = 1'b1;
                out_data_d   = req_data[32'(grant_idx_c)*DATA_W +: DATA_W];
                out_src_d    = grant_idx_c;
                last_grant_d = grant_idx_c;
            end else if (hs_c) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SRC_W'(NUM_REQ - 1);
            entry_cnt_q  <= '0;
`ifdef LVS_ARB_LIMIT_EN
            done_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
            entry_cnt_q  <= entry_cnt_d;
`ifdef LVS_ARB_LIMIT_EN
            done_q       <= done_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign entry_cnt = entry_cnt_q;
`ifdef LVS_ARB_LIMIT_EN
    assign done      = done_q;
`else
    assign done      = 1'b0;
`endif

endmodule

// File: tb/tb_lvs_out_arbiter.sv
// Bench for lvs_out_arbiter: table of single-cycle vectors plus hand-written
// sequences; granted words are queued and compared when they reach the output.
module tb_lvs_out_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_src;
    logic             out_ready;
    logic [7:0]       entry_cnt;
    logic             done;

    lvs_out_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_ENTRIES(47)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .entry_cnt (entry_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic       ordy;
        logic       clr;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] src;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    s;
    } exp_t;

    exp_t          sb[$];
    vec_t          vt[13];
    int            n_checks = 0;
    int            n_fail   = 0;
    int unsigned   cyc      = 0;
    logic          use_fixed = 1'b0;
    logic [DW-1:0] fixed_word =
        256'h0196a3c7_5e2b9d04_f18c6e3a_27b5d9c1_8e4f0a63_d2b71c95_6a3e8f20_c47d4a15;
    logic [DW-1:0] held;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive inputs; each requester's word is unique per cycle
    task automatic set_in(input logic [3:0] rv, input logic ordy, input logic clr, input logic r);
        logic [31:0] w;
        req_valid = rv;
        out_ready = ordy;
        clear     = clr;
        rst       = r;
        for (int i = 0; i < NR; i++) begin
            w = 32'((cyc << 4) | 32'(i));
            if (use_fixed && i == 2) req_data[i*DW +: DW] = fixed_word;
            else                     req_data[i*DW +: DW] = {8{w}};
        end
    endtask

    // Check the grant, queue the expected word, clock, then compare the output
    task automatic step(input logic [3:0] exp_rdy, input string nm);
        exp_t e;
        #1;
        chk({nm, " req_ready"}, DW'(req_ready), DW'(exp_rdy));
        for (int i = 0; i < NR; i++) begin
            if (exp_rdy[i]) begin
                e.d = req_data[i*DW +: DW];
                e.s = 2'(i);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, " out_valid"}, DW'(out_valid), DW'(1));
            chk({nm, " out_data"}, out_data, e.d);
            chk({nm, " out_src"}, DW'(out_src), DW'(e.s));
        end
    endtask

    initial begin
        // rv, ordy, clr, exp ready, exp out_valid, exp src, exp cnt
        vt[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd0};
        vt[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd1};
        vt[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd2};
        vt[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd3};
        vt[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd4};
        vt[5]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd5};
        vt[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd6};
        vt[7]  = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd6};
        vt[8]  = '{4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 8'd6};
        vt[9]  = '{4'b1001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd7};
        vt[10] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd8};
        vt[11] = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd9};
        vt[12] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd10};

        // Reset with every requester asking: no grant while rst is high
        set_in(4'b1111, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        step(4'b0000, "rst0");
        step(4'b0000, "rst1");
        chk("rst out_valid", DW'(out_valid), DW'(0));
        chk("rst out_data", out_data, DW'(0));
        chk("rst out_src", DW'(out_src), DW'(0));
        chk("rst entry_cnt", DW'(entry_cnt), DW'(0));
        chk("rst done", DW'(done), DW'(0));

        // Round-robin, skip of idle requesters, back-pressure, drain to IDLE
        for (int i = 0; i < 13; i++) begin
            set_in(vt[i].rv, vt[i].ordy, vt[i].clr, 1'b0);
            step(vt[i].rdy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d out_valid", i), DW'(out_valid), DW'(vt[i].ov));
            if (vt[i].ov) chk($sformatf("vec%0d src", i), DW'(out_src), DW'(vt[i].src));
            chk($sformatf("vec%0d entry_cnt", i), DW'(entry_cnt), DW'(vt[i].cnt));
        end

        // clear on the same cycle as a handshake at entry_cnt=10
        set_in(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0001, "clr_load");
        chk("clr_load cnt", DW'(entry_cnt), DW'(10));
        set_in(4'b1111, 1'b1, 1'b1, 1'b0);
        step(4'b0000, "clr_hs");
        chk("clr_hs out_valid", DW'(out_valid), DW'(0));
        chk("clr_hs cnt", DW'(entry_cnt), DW'(0));
        set_in(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, "clr_after");
        chk("clr_after cnt", DW'(entry_cnt), DW'(0));

        // Requester 2 alone with a fixed word, then held under back-pressure
        use_fixed = 1'b1;
        set_in(4'b0100, 1'b0, 1'b0, 1'b0);
        step(4'b0100, "fix_load");
        chk("fix_load data", out_data, fixed_word);
        held = out_data;
        use_fixed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(4'b1111, 1'b0, 1'b0, 1'b0);
            step(4'b0000, $sformatf("hold%0d", i));
            chk($sformatf("hold%0d data", i), out_data, held);
            chk($sformatf("hold%0d src", i), DW'(out_src), DW'(2));
            chk($sformatf("hold%0d ov", i), DW'(out_valid), DW'(1));
            chk($sformatf("hold%0d cnt", i), DW'(entry_cnt), DW'(0));
        end
        set_in(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, "hold_drain");
        chk("hold_drain cnt", DW'(entry_cnt), DW'(1));
        chk("hold_drain ov", DW'(out_valid), DW'(0));
        set_in(4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'b0000, "pre_run_clear");
        chk("pre_run cnt", DW'(entry_cnt), DW'(0));

        // Long run, all requesting; last grant was 2 so order starts at 3
`ifdef LVS_ARB_LIMIT_EN
        for (int c = 0; c < 48; c++) begin
            set_in(4'b1111, 1'b1, 1'b0, 1'b0);
            step((c == 47) ? 4'b0000 : 4'(1 << ((3 + c) % 4)), $sformatf("run%0d", c));
            if (c == 46) begin
                chk("run46 cnt", DW'(entry_cnt), DW'(46));
                chk("run46 done", DW'(done), DW'(0));
            end
        end
        chk("limit done", DW'(done), DW'(1));
        chk("limit cnt", DW'(entry_cnt), DW'(47));
        chk("limit ov", DW'(out_valid), DW'(0));
        for (int i = 0; i < 3; i++) begin
            set_in(4'b1111, 1'b1, 1'b0, 1'b0);
            step(4'b0000, $sformatf("done%0d", i));
            chk($sformatf("done%0d done", i), DW'(done), DW'(1));
            chk($sformatf("done%0d cnt", i), DW'(entry_cnt), DW'(47));
        end
        set_in(4'b1111, 1'b1, 1'b1, 1'b0);
        step(4'b0000, "done_clear");
        chk("done_clear done", DW'(done), DW'(0));
        chk("done_clear cnt", DW'(entry_cnt), DW'(0));
        set_in(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b0100, "resume");
        set_in(4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'b0000, "resume_clear");
`else
        for (int c = 0; c < 257; c++) begin
            set_in(4'b1111, 1'b1, 1'b0, 1'b0);
            step(4'(1 << ((3 + c) % 4)), $sformatf("run%0d", c));
            if (c == 47) begin
                chk("run47 cnt", DW'(entry_cnt), DW'(47));
                chk("run47 done", DW'(done), DW'(0));
            end
            if (c == 255) chk("run255 cnt", DW'(entry_cnt), DW'(255));
        end
        chk("wrap cnt", DW'(entry_cnt), DW'(0));
        chk("wrap done", DW'(done), DW'(0));
        set_in(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, "wrap_drain");
        chk("wrap_drain cnt", DW'(entry_cnt), DW'(1));
        set_in(4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'b0000, "wrap_clear");
`endif

        // rst while BUSY: word dropped, priority back to requester 0
        set_in(4'b0001, 1'b0, 1'b0, 1'b0);
        step(4'b0001, "busy_load");
        set_in(4'b1111, 1'b1, 1'b0, 1'b1);
        step(4'b0000, "busy_rst");
        chk("busy_rst ov", DW'(out_valid), DW'(0));
        chk("busy_rst cnt", DW'(entry_cnt), DW'(0));
        chk("busy_rst data", out_data, DW'(0));
        chk("busy_rst done", DW'(done), DW'(0));
        set_in(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b0001, "post_rst");
        chk("post_rst src", DW'(out_src), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
